// File: rtl/board_select_ctrl.sv
// Tic-tac-toe game state for the VGA overlay: decodes mouse clicks into board
// squares, tracks ownership and turn order, and reports win/draw results.
module board_select_ctrl #(
    parameter logic [11:0] COL0_END   = 12'd340,
    parameter logic [11:0] COL1_START = 12'd343,
    parameter logic [11:0] COL1_END   = 12'd682,
    parameter logic [11:0] COL2_START = 12'd685,
    parameter logic [11:0] COL2_END   = 12'd1023,
    parameter logic [11:0] ROW0_END   = 12'd254,
    parameter logic [11:0] ROW1_START = 12'd257,
    parameter logic [11:0] ROW1_END   = 12'd512,
    parameter logic [11:0] ROW2_START = 12'd515,
    parameter logic [11:0] ROW2_END   = 12'd767
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        start_en,
    input  logic        choice_en,
    input  logic        first_player,
    input  logic        new_game,
    output logic [8:0]  square,
    output logic [8:0]  square_color,
    output logic        player,
    output logic        game_over,
    output logic [1:0]  winner
);

    typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

    state_t      r_state, w_next_state;
    logic        r_s1, r_s2, r_s3;
    logic [8:0]  r_square, r_color;
    logic        r_player, r_game_over;
    logic [1:0]  r_winner;

    logic        w_click, w_col_ok, w_row_ok, w_hit;
    logic [1:0]  w_col, w_row, w_line, w_result;
    logic [3:0]  w_idx;
    logic        w_place, w_load, w_finish;

    function automatic logic [1:0] line_owner(input logic [8:0] sq, input logic [8:0] col,
                                              input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        if (sq[a] & sq[b] & sq[c] & (col[a] == col[b]) & (col[b] == col[c]))
            return col[a] ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    assign w_click = r_s2 & ~r_s3;

    always_comb begin
        w_col_ok = 1'b1;
        w_col    = 2'd0;
        if (xpos <= COL0_END)                              w_col = 2'd0;
        else if (xpos >= COL1_START && xpos <= COL1_END)   w_col = 2'd1;
        else if (xpos >= COL2_START && xpos <= COL2_END)   w_col = 2'd2;
        else                                               w_col_ok = 1'b0;
        w_row_ok = 1'b1;
        w_row    = 2'd0;
        if (ypos <= ROW0_END)                              w_row = 2'd0;
        else if (ypos >= ROW1_START && ypos <= ROW1_END)   w_row = 2'd1;
        else if (ypos >= ROW2_START && ypos <= ROW2_END)   w_row = 2'd2;
        else                                               w_row_ok = 1'b0;
    end

    assign w_hit = w_col_ok & w_row_ok;
    assign w_idx = {2'b00, w_row} * 4'd3 + {2'b00, w_col};

    // Only the square just placed can complete a line, so at most one owner is non-zero.
    always_comb begin
        w_line = 2'b00;
        w_line = w_line | line_owner(r_square, r_color, 4'd0, 4'd1, 4'd2);
        w_line = w_line | line_owner(r_square, r_color, 4'd3, 4'd4, 4'd5);
        w_line = w_line | line_owner(r_square, r_color, 4'd6, 4'd7, 4'd8);
        w_line = w_line | line_owner(r_square, r_color, 4'd0, 4'd3, 4'd6);
        w_line = w_line | line_owner(r_square, r_color, 4'd1, 4'd4, 4'd7);
        w_line = w_line | line_owner(r_square, r_color, 4'd2, 4'd5, 4'd8);
        w_line = w_line | line_owner(r_square, r_color, 4'd0, 4'd4, 4'd8);
        w_line = w_line | line_owner(r_square, r_color, 4'd2, 4'd4, 4'd6);
    end

    always_comb begin
        w_next_state = r_state;
        w_place      = 1'b0;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        w_result     = 2'b00;
        case (r_state)
            IDLE: if (start_en & ~choice_en) begin
                w_load       = 1'b1;
                w_next_state = PLAY;
            end
            PLAY: if (~start_en) begin
                w_next_state = IDLE;
            end else if (w_click & ~choice_en & w_hit & ~r_square[w_idx]) begin
                w_place      = 1'b1;
                w_next_state = CHECK;
            end
            CHECK: if (w_line != 2'b00) begin
                w_finish     = 1'b1;
                w_result     = w_line;
                w_next_state = OVER;
            end else if (&r_square) begin
                w_finish     = 1'b1;
                w_result     = 2'b11;
                w_next_state = OVER;
            end else begin
                w_next_state = PLAY;
            end
            OVER:    w_next_state = OVER;
            default: w_next_state = IDLE;
        endcase
        if (new_game) w_next_state = IDLE;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= mouse_left;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_square    <= '0;
            r_color     <= '0;
            r_player    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else if (new_game) begin
            r_square    <= '0;
            r_color     <= '0;
            r_player    <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 2'b00;
        end else begin
            if (w_load) r_player <= first_player;
            if (w_place) begin
                r_square[w_idx] <= 1'b1;
                r_color[w_idx]  <= r_player;
                r_player        <= ~r_player;
            end
            if (w_finish) begin
                r_game_over <= 1'b1;
                r_winner    <= w_result;
            end
        end
    end

    assign square       = r_square;
    assign square_color = r_color;
    assign player       = r_player;
    assign game_over    = r_game_over;
    assign winner       = r_winner;

endmodule
